// File: rtl/sort_e2_merge_if.sv
// Handshake/bus bundle between the first-level sorter and sort_e2_merge.
// master: upstream side (drives lines, clear); slave: the merge stage.
interface sort_e2_merge_if #(
    parameter int Data_Width      = 8,
    parameter int Index_Width     = 16,
    parameter int Out_Index_Width = Index_Width + 5,
    parameter int Depth           = 5
);
    localparam int InW  = Index_Width + Data_Width;
    localparam int OutW = Out_Index_Width + Data_Width;

    logic                   sorter_clr;
    logic                   in_valid;
    logic                   in_last;
    logic [Index_Width-1:0] in_line_cnt;
    logic [Depth*InW-1:0]   in_l;
    logic [Depth*InW-1:0]   in_h;
    logic                   out_valid;
    logic [Depth*OutW-1:0]  top_out;
    logic                   busy;
    logic                   overflow;

    modport master (
        output sorter_clr, in_valid, in_last, in_line_cnt, in_l, in_h,
        input  out_valid, top_out, busy, overflow
    );

    modport slave (
        input  sorter_clr, in_valid, in_last, in_line_cnt, in_l, in_h,
        output out_valid, top_out, busy, overflow
    );
endinterface

// File: rtl/sort_e2_merge.sv
// Second-level top-5 merge: folds the low/high lists of each line into a
// running global top-5 and publishes it (value + global index) on the last line.
// Ports: sys_clk, sys_rst_n (async, active-low), bus (sort_e2_merge_if.slave):
//   sorter_clr, in_valid, in_last, in_line_cnt, in_l, in_h -> out_valid,
//   top_out, busy, overflow.
module sort_e2_merge #(
    parameter int Data_Width      = 8,
    parameter int Index_Width     = 16,
    parameter int Out_Index_Width = Index_Width + 5,
    parameter int Depth           = 5
) (
    input logic            sys_clk,
    input logic            sys_rst_n,
    sort_e2_merge_if.slave bus
);
    localparam int InW  = Index_Width + Data_Width;
    localparam int OutW = Out_Index_Width + Data_Width;
    localparam int PtrW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] Full = PtrW'(Depth);
    localparam logic [PtrW-1:0] Last = PtrW'(Depth - 1);
    localparam logic [Data_Width-1:0] Min = {1'b1, {(Data_Width-1){1'b0}}};

    typedef enum logic {IDLE, MERGE} state_t;

    state_t state_q, state_d;

    logic [Data_Width-1:0]      run_d [Depth];
    logic [Out_Index_Width-1:0] run_g [Depth];
    logic                       run_v [Depth];

    logic [Data_Width-1:0]      cap_l_d [Depth];
    logic [Out_Index_Width-1:0] cap_l_g [Depth];
    logic [Data_Width-1:0]      cap_h_d [Depth];
    logic [Out_Index_Width-1:0] cap_h_g [Depth];

    logic [Data_Width-1:0]      mrg_d [Depth];
    logic [Out_Index_Width-1:0] mrg_g [Depth];
    logic                       mrg_v [Depth];

    logic [Data_Width-1:0]      fin_d [Depth];
    logic [Out_Index_Width-1:0] fin_g [Depth];
    logic                       fin_v [Depth];

    logic [Data_Width-1:0]      in_l_d [Depth];
    logic [Out_Index_Width-1:0] in_l_g [Depth];
    logic [Data_Width-1:0]      in_h_d [Depth];
    logic [Out_Index_Width-1:0] in_h_g [Depth];

    logic [PtrW-1:0] pr, pl, ph, k;
    logic            last_q;
    logic            out_valid_q;
    logic            overflow_q;
    logic [Depth*OutW-1:0] top_q, top_d;
    logic [Index_Width-1:0] line_base;

    logic                       r_v, l_v, h_v, win_v;
    logic [Data_Width-1:0]      r_d, l_d, h_d, win_d;
    logic [Out_Index_Width-1:0] r_g, l_g, h_g, win_g;
    logic                       sel_r, sel_l, sel_h;

    logic unused_idx;

    function automatic logic beats(
        input logic                  av,
        input logic [Data_Width-1:0] ad,
        input logic                  bv,
        input logic [Data_Width-1:0] bd
    );
        return av && (!bv || ($signed(ad) > $signed(bd)));
    endfunction

    // Only idx[4:0] is meaningful; the line number supplies the upper bits.
    assign line_base = bus.in_line_cnt - {{(Index_Width-1){1'b0}}, 1'b1};
    assign unused_idx = ^{bus.in_l, bus.in_h};

    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            in_l_d[i] = bus.in_l[i*InW +: Data_Width];
            in_h_d[i] = bus.in_h[i*InW +: Data_Width];
            in_l_g[i] = {line_base, bus.in_l[i*InW + Data_Width +: 5]};
            in_h_g[i] = {line_base, bus.in_h[i*InW + Data_Width +: 5]};
        end
    end

    // Exhausted lists present an invalid head so they never win.
    always_comb begin
        r_v = 1'b0;
        r_d = Min;
        r_g = '0;
        l_v = 1'b0;
        l_d = Min;
        l_g = '0;
        h_v = 1'b0;
        h_d = Min;
        h_g = '0;
        if (pr < Full) begin
            r_v = run_v[pr];
            r_d = run_d[pr];
            r_g = run_g[pr];
        end
        if (pl < Full) begin
            l_v = 1'b1;
            l_d = cap_l_d[pl];
            l_g = cap_l_g[pl];
        end
        if (ph < Full) begin
            h_v = 1'b1;
            h_d = cap_h_d[ph];
            h_g = cap_h_g[ph];
        end
    end

    // Strict "beats" tests give ties to run, then L, then H.
    always_comb begin
        sel_r = !beats(l_v, l_d, r_v, r_d) && !beats(h_v, h_d, r_v, r_d);
        sel_l = !sel_r && !beats(h_v, h_d, l_v, l_d);
        sel_h = !sel_r && !sel_l;
        win_v = 1'b0;
        win_d = Min;
        win_g = '0;
        unique case (1'b1)
            sel_r: begin
                win_v = r_v;
                win_d = r_d;
                win_g = r_g;
            end
            sel_l: begin
                win_v = l_v;
                win_d = l_d;
                win_g = l_g;
            end
            sel_h: begin
                win_v = h_v;
                win_d = h_d;
                win_g = h_g;
            end
            default: ;
        endcase
    end

    // Merged list as it stands after this cycle's winner lands in the last slot.
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            fin_d[i] = mrg_d[i];
            fin_g[i] = mrg_g[i];
            fin_v[i] = mrg_v[i];
        end
        fin_d[Depth-1] = win_d;
        fin_g[Depth-1] = win_g;
        fin_v[Depth-1] = win_v;
        top_d = '0;
        for (int i = 0; i < Depth; i++) begin
            top_d[i*OutW +: OutW] = {fin_g[i], fin_d[i]};
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.sorter_clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (bus.in_valid) state_d = MERGE;
                MERGE:   if (k == Last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pr          <= '0;
            pl          <= '0;
            ph          <= '0;
            k           <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            top_q       <= '0;
            for (int i = 0; i < Depth; i++) begin
                run_d[i]   <= Min;
                run_g[i]   <= '0;
                run_v[i]   <= 1'b0;
                cap_l_d[i] <= Min;
                cap_l_g[i] <= '0;
                cap_h_d[i] <= Min;
                cap_h_g[i] <= '0;
                mrg_d[i]   <= Min;
                mrg_g[i]   <= '0;
                mrg_v[i]   <= 1'b0;
            end
        end else if (bus.sorter_clr) begin
            pr          <= '0;
            pl          <= '0;
            ph          <= '0;
            k           <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            top_q       <= '0;
            for (int i = 0; i < Depth; i++) begin
                run_d[i] <= Min;
                run_g[i] <= '0;
                run_v[i] <= 1'b0;
                mrg_v[i] <= 1'b0;
            end
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        last_q <= bus.in_last;
                        pr     <= '0;
                        pl     <= '0;
                        ph     <= '0;
                        k      <= '0;
                        for (int i = 0; i < Depth; i++) begin
                            cap_l_d[i] <= in_l_d[i];
                            cap_l_g[i] <= in_l_g[i];
                            cap_h_d[i] <= in_h_d[i];
                            cap_h_g[i] <= in_h_g[i];
                        end
                    end
                end
                MERGE: begin
                    if (bus.in_valid) overflow_q <= 1'b1;
                    mrg_d[k] <= win_d;
                    mrg_g[k] <= win_g;
                    mrg_v[k] <= win_v;
                    if (sel_r) pr <= pr + 1'b1;
                    if (sel_l) pl <= pl + 1'b1;
                    if (sel_h) ph <= ph + 1'b1;
                    k <= k + 1'b1;
                    if (k == Last) begin
                        if (last_q) begin
                            top_q       <= top_d;
                            out_valid_q <= 1'b1;
                            for (int i = 0; i < Depth; i++) begin
                                run_d[i] <= Min;
                                run_g[i] <= '0;
                                run_v[i] <= 1'b0;
                            end
                        end else begin
                            for (int i = 0; i < Depth; i++) begin
                                run_d[i] <= fin_d[i];
                                run_g[i] <= fin_g[i];
                                run_v[i] <= fin_v[i];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.top_out   = top_q;
    assign bus.busy      = (state_q == MERGE);
    assign bus.overflow  = overflow_q;
endmodule

// File: doc/sort_e2_merge.md
Name: sort_e2_merge

Overview:
- Downstream stage of the first-level top-5 sorter in the NPU core sort path.
- Each first-level result carries two descending top-5 lists: low half (lanes 0-15) and high half (lanes 16-31).
- This block merges both lists with a running global top-5 kept across all lines of a sort job.
- On the last line it publishes the final global top-5 (signed int8 value plus global element index).

Parameters:
Data_Width, 8, signed score width; MIN = 8'h80
Index_Width, 16, incoming local index / line counter width
Out_Index_Width, 21, global index width = Index_Width + 5
Depth, 5, entries per list (fixed; not intended to be changed)

Ports:
sys_clk  input  1  clock
sys_rst_n  input  1  async active-low reset
sorter_clr  input  1  sync clear of all state, same cycle as upstream clear
in_valid  input  1  single-cycle pulse: in_l/in_h/in_line_cnt/in_last valid
in_last  input  1  qualifies in_valid: this line completes the job
in_line_cnt  input  16  line number, 1-based (first line = 1)
in_l  input  120  5 x {idx[15:0], data[7:0]}, entry 0 at [23:0], descending
in_h  input  120  same layout, high-half list
out_valid  output  1  single-cycle pulse: top_out holds the final result
top_out  output  145  5 x {gidx[20:0], data[7:0]}, entry 0 (largest) at [28:0]
busy  output  1  high while not IDLE
overflow  output  1  sticky: in_valid arrived while busy

Behaviour:
- Reset (sys_rst_n low, async): all outputs 0; FSM IDLE; running list cleared (all valid bits 0, data MIN, gidx 0).
- sorter_clr has the same effect synchronously, overrides everything, and aborts any merge in progress without an out_valid.
- Global index: gidx = {in_line_cnt - 1, idx[4:0]}. Only the low 5 bits of the local index are used.
- Comparison: signed Data_Width. Each entry has a valid bit. A valid entry always beats an invalid one.
- Incoming entries are always valid, including entries whose data is MIN.
- Tie on equal data: running list wins, then L, then H (earlier/lower index preferred).
- FSM states: IDLE, MERGE.
- IDLE: an edge sampling in_valid=1 captures in_l/in_h (with gidx converted), latches in_last, clears pointers pr/pl/ph to 0 and k to 0, and moves to MERGE.
- MERGE: each cycle compares heads run[pr], L[pl], H[ph]. An exhausted list (pointer = 5) presents an invalid head.
  - The winner is written to new[k] and its pointer increments.
  - k increments; when k=4 the state returns to IDLE on the same edge.
- Commit, on the k=4 edge:
  - If in_last=0: run <= new.
  - If in_last=1: top_out <= new, out_valid <= 1 for one cycle, and run is cleared to empty for the next job.
- Latency: out_valid rises on the 5th edge after the edge that sampled in_valid.
- Accept interval: 6 cycles, matching the upstream minimum sort_en spacing. busy=1 in MERGE.
- in_valid while busy: input dropped, overflow <= 1. overflow is cleared only by reset or sorter_clr.
- top_out holds its value until the next final commit, sorter_clr or reset. out_valid is 0 otherwise.
- Simultaneous sorter_clr and in_valid: clear wins and the input is dropped.

Test Plan:
1. Single line, in_last=1, line_cnt=1, L data {50,40,30,20,10} idx 0-4, H data {45,35,25,15,5} idx 16-20.
   - Expected: out_valid 5 edges later; top_out data {50,45,40,35,30}, gidx {0,16,1,17,2}.
2. Two lines: line1 (last=0) L/H all data 10; line2 (last=1) L {127,10,-1,-2,-3} idx 3,..., H all MIN.
   - Expected: top_out {127@gidx 35, then four 10s from line1 with gidx 0,1,2,3} (tie rule: running list wins).
3. Signed check, last=1: L {-5,-6,-7,-8,-9}, H {0x7F,0x80,0x80,0x80,0x80}.
   - Expected: top_out data {127,-5,-6,-7,-8}.
4. in_valid pulse 3 cycles after an accepted one.
   - Expected: overflow=1 and stays 1; result equals the first line only. sorter_clr then returns overflow=0.
5. sorter_clr asserted at MERGE k=2.
   - Expected: no out_valid; busy=0 next cycle; a following single last line yields only its own top-5 with no stale entries.
6. Back-to-back lines exactly 6 cycles apart over 3 lines (last on 3rd), values chosen so each line contributes one winner.
   - Expected: no overflow; winners from lines 1, 2, 3 with gidx high bits 0, 1, 2.
